// File: rtl/ps2_key_decoder_pkg.sv
// rtl/ps2_key_decoder_pkg.sv - shared PS/2 keycodes, frame states and event layout
package ps2_key_decoder_pkg;

    localparam logic [7:0] KC_EXTENDED = 8'hE0;
    localparam logic [7:0] KC_BREAK    = 8'hF0;

    // Keypad set-2 make codes (enter shares 0x5A and arrives behind 0xE0)
    localparam logic [7:0] KC_KP_0     = 8'h70;
    localparam logic [7:0] KC_KP_1     = 8'h69;
    localparam logic [7:0] KC_KP_2     = 8'h72;
    localparam logic [7:0] KC_KP_3     = 8'h7A;
    localparam logic [7:0] KC_KP_4     = 8'h6B;
    localparam logic [7:0] KC_KP_5     = 8'h73;
    localparam logic [7:0] KC_KP_6     = 8'h74;
    localparam logic [7:0] KC_KP_7     = 8'h6C;
    localparam logic [7:0] KC_KP_8     = 8'h75;
    localparam logic [7:0] KC_KP_9     = 8'h7D;
    localparam logic [7:0] KC_KP_DOT   = 8'h71;
    localparam logic [7:0] KC_KP_PLUS  = 8'h79;
    localparam logic [7:0] KC_KP_MINUS = 8'h7B;
    localparam logic [7:0] KC_KP_STAR  = 8'h7C;
    localparam logic [7:0] KC_KP_ENTER = 8'h5A;

    localparam int EVENT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    typedef struct packed {
        logic       extended;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

endpackage

// File: rtl/ps2_key_decoder_fifo.sv
// rtl/ps2_key_decoder_fifo.sv - show-ahead event FIFO with overflow pulse
module key_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     ck,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_req,
    output logic                     valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop_req && !empty;
    // A pop in the same cycle frees the slot the push needs
    assign do_push = push && (!full || do_pop);

    assign valid     = !empty;
    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge ck) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push && full && !do_pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard frame receiver with make/break/extended decode
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          ck,
    input  logic                          reset,
    input  logic                          PS2C,
    input  logic                          PS2D,
    input  logic                          key_ready,
    output logic                          key_valid,
    output logic [7:0]                    key_code,
    output logic                          key_release,
    output logic                          key_extended,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic           ps2c_meta, ps2c_sync, ps2d_meta, ps2d_sync;
    logic           ps2c_filt, ps2c_filt_d;
    logic [FCW-1:0] filt_cnt;
    logic           fall;

    frame_state_t   state, state_n;
    logic [2:0]     bit_cnt, bit_cnt_n;
    logic [7:0]     shreg, shreg_n;
    logic           par_bit, par_bit_n;
    logic [WDW-1:0] wd_cnt, wd_cnt_n;
    logic           pend_ext, pend_ext_n, pend_brk, pend_brk_n;
    logic           ev_push, ev_push_n;
    key_event_t     ev_data, ev_data_n;
    logic           parity_err_n, frame_err_n;
    logic           timeout;
    key_event_t     head;

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            ps2c_meta   <= 1'b0;
            ps2c_sync   <= 1'b0;
            ps2d_meta   <= 1'b0;
            ps2d_sync   <= 1'b0;
            ps2c_filt   <= 1'b0;
            ps2c_filt_d <= 1'b0;
            filt_cnt    <= '0;
        end else begin
            ps2c_meta   <= PS2C;
            ps2c_sync   <= ps2c_meta;
            ps2d_meta   <= PS2D;
            ps2d_sync   <= ps2d_meta;
            ps2c_filt_d <= ps2c_filt;
            // Any sample agreeing with the filtered level restarts the run
            if (ps2c_sync == ps2c_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
                ps2c_filt <= ps2c_sync;
                filt_cnt  <= '0;
            end else begin
                filt_cnt <= filt_cnt + FCW'(1);
            end
        end
    end

    assign fall    = ps2c_filt_d && !ps2c_filt;
    assign timeout = (state != ST_IDLE) && !fall && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            wd_cnt     <= '0;
            pend_ext   <= 1'b0;
            pend_brk   <= 1'b0;
            ev_push    <= 1'b0;
            ev_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            par_bit    <= par_bit_n;
            wd_cnt     <= wd_cnt_n;
            pend_ext   <= pend_ext_n;
            pend_brk   <= pend_brk_n;
            ev_push    <= ev_push_n;
            ev_data    <= ev_data_n;
            parity_err <= parity_err_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        par_bit_n    = par_bit;
        pend_ext_n   = pend_ext;
        pend_brk_n   = pend_brk;
        ev_push_n    = 1'b0;
        ev_data_n    = ev_data;
        parity_err_n = 1'b0;
        frame_err_n  = 1'b0;
        wd_cnt_n     = (state == ST_IDLE) ? '0 : wd_cnt + WDW'(1);

        if (fall) begin
            wd_cnt_n = '0;
            case (state)
                ST_IDLE: begin
                    if (!ps2d_sync) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = '0;
                    end else begin
                        frame_err_n = 1'b1;
                        pend_ext_n  = 1'b0;
                        pend_brk_n  = 1'b0;
                    end
                end
                ST_DATA: begin
                    shreg_n = {ps2d_sync, shreg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_n = ST_PARITY;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_bit_n = ps2d_sync;
                    state_n   = ST_STOP;
                end
                ST_STOP: begin
                    state_n = ST_IDLE;
                    if (!ps2d_sync) begin
                        frame_err_n = 1'b1;
                        pend_ext_n  = 1'b0;
                        pend_brk_n  = 1'b0;
                    end else if (!(^{shreg, par_bit})) begin
                        parity_err_n = 1'b1;
                        pend_ext_n   = 1'b0;
                        pend_brk_n   = 1'b0;
                    end else if (shreg == KC_EXTENDED) begin
                        pend_ext_n = 1'b1;
                    end else if (shreg == KC_BREAK) begin
                        pend_brk_n = 1'b1;
                    end else begin
                        ev_push_n  = 1'b1;
                        ev_data_n  = '{extended: pend_ext, brk: pend_brk, code: shreg};
                        pend_ext_n = 1'b0;
                        pend_brk_n = 1'b0;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (timeout) begin
            state_n     = ST_IDLE;
            wd_cnt_n    = '0;
            frame_err_n = 1'b1;
            pend_ext_n  = 1'b0;
            pend_brk_n  = 1'b0;
        end
    end

    key_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .ck        (ck),
        .reset     (reset),
        .push      (ev_push),
        .push_data (ev_data),
        .pop_req   (key_ready),
        .valid     (key_valid),
        .head_data (head),
        .count     (fifo_count),
        .overflow  (overflow)
    );

    assign key_code     = head.code;
    assign key_release  = head.brk;
    assign key_extended = head.extended;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - randomized self-checking bench with event-level reference model
module tb_ps2_key_decoder;
    localparam int FL    = 4;
    localparam int TO    = 300;
    localparam int DEPTH = 4;
    localparam int H     = 20;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic       PS2C = 1'b1;
    logic       PS2D = 1'b1;
    logic       key_ready = 1'b0;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_release;
    logic       key_extended;
    logic [2:0] fifo_count;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    ps2_key_decoder #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .ck           (ck),
        .reset        (reset),
        .PS2C         (PS2C),
        .PS2D         (PS2D),
        .key_ready    (key_ready),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_release  (key_release),
        .key_extended (key_extended),
        .fifo_count   (fifo_count),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overflow     (overflow)
    );

    always #5 ck = ~ck;

    int errors = 0;
    int checks = 0;
    logic [9:0] mq[$];
    bit pend_ext = 0;
    bit pend_brk = 0;
    int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
    int n_perr = 0, n_ferr = 0, n_ovf = 0;
    bit rand_ready = 0;
    bit ready_fixed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge ck);
        #1;
    endtask

    // Reference model: one completed frame at byte level
    task automatic model_byte(input logic [7:0] b, input bit par_good, input bit stop_good);
        if (!stop_good) begin
            exp_ferr++;
            pend_ext = 0;
            pend_brk = 0;
        end else if (!par_good) begin
            exp_perr++;
            pend_ext = 0;
            pend_brk = 0;
        end else if (b == 8'hE0) begin
            pend_ext = 1;
        end else if (b == 8'hF0) begin
            pend_brk = 1;
        end else begin
            if (mq.size() >= DEPTH) exp_ovf++;
            else mq.push_back({pend_ext, pend_brk, b});
            pend_ext = 0;
            pend_brk = 0;
        end
    endtask

    task automatic send_bit(input logic b);
        PS2D = b;
        wait_cyc(H / 2);
        PS2C = 1'b0;
        wait_cyc(H);
        PS2C = 1'b1;
        wait_cyc(H / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_good = 1, input bit stop_good = 1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par_good ? ~^b : ^b);
        PS2D = stop_good;
        wait_cyc(H / 2);
        PS2C = 1'b0;
        model_byte(b, par_good, stop_good);
        wait_cyc(H);
        PS2C = 1'b1;
        wait_cyc(H / 2);
        PS2D = 1'b1;
        wait_cyc(H);
    endtask

    task automatic drain();
        ready_fixed = 1;
        for (int i = 0; i < 200; i++) begin
            wait_cyc(1);
            if (mq.size() == 0 && !key_valid) break;
        end
        check("drain_model_empty", mq.size(), 0);
        check("drain_valid_low", key_valid, 0);
        ready_fixed = 0;
        wait_cyc(2);
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_parity_err_pulses"}, n_perr, exp_perr);
        check({tag, "_frame_err_pulses"}, n_ferr, exp_ferr);
        check({tag, "_overflow_pulses"}, n_ovf, exp_ovf);
    endtask

    initial begin
        forever begin
            @(posedge ck);
            #2;
            key_ready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_fixed;
        end
    end

    initial begin
        forever begin
            @(negedge ck);
            if (!reset) begin
                n_perr += int'(parity_err);
                n_ferr += int'(frame_err);
                n_ovf  += int'(overflow);
            end
        end
    end

    // Per-cycle compare against the model queue
    initial begin
        logic [9:0] exp_ev;
        forever begin
            @(negedge ck);
            if (!reset) begin
                check("valid_vs_count", key_valid, fifo_count != 0);
                if (!key_valid)
                    check("empty_head_zero", {key_extended, key_release, key_code}, 10'h0);
                if (key_valid && key_ready) begin
                    if (mq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: got %0h expected no event", {key_extended, key_release, key_code});
                    end else begin
                        exp_ev = mq.pop_front();
                        check("popped_event", {key_extended, key_release, key_code}, exp_ev);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int mode;

        #1;
        check("reset_valid", key_valid, 0);
        check("reset_count", fifo_count, 0);
        check("reset_code", key_code, 0);
        check("reset_errs", {parity_err, frame_err, overflow}, 0);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(20);

        // Single make code 0x69
        send_frame(8'h69);
        check("t69_count", fifo_count, 1);
        check("t69_code", key_code, 8'h69);
        check("t69_release", key_release, 0);
        check("t69_extended", key_extended, 0);
        drain();

        // Extended break sequence
        send_frame(8'hE0);
        check("e0_no_event", fifo_count, 0);
        send_frame(8'hF0);
        check("f0_no_event", fifo_count, 0);
        send_frame(8'h5A);
        check("e0f05a_count", fifo_count, 1);
        check("e0f05a_code", key_code, 8'h5A);
        check("e0f05a_extended", key_extended, 1);
        check("e0f05a_release", key_release, 1);
        drain();

        // Bad parity then recovery
        send_frame(8'h69, 0);
        check("badpar_pulses", n_perr, 1);
        check("badpar_no_event", fifo_count, 0);
        send_frame(8'h16);
        check("after_badpar_code", key_code, 8'h16);
        check("after_badpar_flags", {key_extended, key_release}, 2'b00);
        drain();

        // Overflow with consumer stalled
        send_frame(8'h15);
        send_frame(8'h1D);
        send_frame(8'h24);
        send_frame(8'h2D);
        send_frame(8'h2C);
        check("ovf_count", fifo_count, 4);
        check("ovf_pulses", n_ovf, 1);
        check("ovf_head", key_code, 8'h15);
        drain();

        // Start bit of 1 is a glitch
        send_bit(1'b1);
        exp_ferr++;
        wait_cyc(H);
        check("glitch_frame_err", n_ferr, 1);

        // Watchdog: clock stuck low after 4 data bits
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        PS2D = 1'b0;
        wait_cyc(H / 2);
        PS2C = 1'b0;
        wait_cyc(TO + FL + 20);
        exp_ferr++;
        pend_ext = 0;
        pend_brk = 0;
        PS2C = 1'b1;
        PS2D = 1'b1;
        wait_cyc(H);
        check("timeout_frame_err", n_ferr, 2);
        check("timeout_no_event", fifo_count, 0);
        send_frame(8'h72);
        check("after_timeout_code", key_code, 8'h72);
        check("after_timeout_count", fifo_count, 1);
        drain();
        check_errs("directed");

        // Randomized traffic with a randomly stalling consumer
        rand_ready = 1;
        for (int n = 0; n < 30; n++) begin
            mode = $urandom_range(0, 19);
            case ($urandom_range(0, 7))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_frame(b, mode > 2 || mode == 0, mode != 0);
        end
        rand_ready = 0;
        wait_cyc(H);
        drain();
        check_errs("random");

        // Asynchronous reset with events queued and a frame in flight
        send_frame(8'h1C);
        send_frame(8'h32);
        check("prereset_count", fifo_count, 2);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        PS2C = 1'b0;
        wait_cyc(3);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_valid", key_valid, 0);
        check("async_reset_count", fifo_count, 0);
        mq.delete();
        pend_ext = 0;
        pend_brk = 0;
        PS2C = 1'b1;
        PS2D = 1'b1;
        wait_cyc(4);
        reset = 1'b0;
        wait_cyc(100);
        check("postreset_no_stale", fifo_count, 0);
        send_frame(8'h4B);
        check("postreset_code", key_code, 8'h4B);
        check("postreset_count", fifo_count, 1);
        drain();
        check_errs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
